// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep sequencer feeding K/P words to a DDS phase accumulator.
// Holds each frequency dwell+1 cycles; single-shot or continuous, abortable.
module dds_sweep_ctrl #(
   parameter int KW = 32,
   parameter int PW = 11,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          mode,
   input  logic [KW-1:0] f_start,
   input  logic [KW-1:0] f_stop,
   input  logic [KW-1:0] f_step,
   input  logic [DW-1:0] dwell,
   input  logic [PW-1:0] p_offset,
   output logic [KW-1:0] K,
   output logic [PW-1:0] P,
   output logic          busy,
   output logic          done,
   output logic          cfg_err
);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   localparam logic [DW-1:0] CNT_ONE = DW'(1);

   state_t        state_q;
   logic [KW-1:0] k_q;
   logic [PW-1:0] p_q;
   logic          busy_q;
   logic          done_q;
   logic          cfg_err_q;
   logic [DW-1:0] cnt_q;
   logic [KW-1:0] f_start_q;
   logic [KW-1:0] f_stop_q;
   logic [KW-1:0] f_step_q;
   logic [DW-1:0] dwell_q;
   logic          mode_q;

   logic [KW:0]   nxt_d;
   logic          cfg_ok_d;
   logic          in_range_d;

   // Extra bit catches wrap past 2^KW so it never becomes a sweep point
   assign nxt_d      = {1'b0, k_q} + {1'b0, f_step_q};
   assign in_range_d = !nxt_d[KW] && (nxt_d[KW-1:0] <= f_stop_q);
   assign cfg_ok_d   = (f_step != '0) && (f_start <= f_stop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         p_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         cnt_q     <= '0;
         f_start_q <= '0;
         f_stop_q  <= '0;
         f_step_q  <= '0;
         dwell_q   <= '0;
         mode_q    <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  if (cfg_ok_d) begin
                     f_start_q <= f_start;
                     f_stop_q  <= f_stop;
                     f_step_q  <= f_step;
                     dwell_q   <= dwell;
                     mode_q    <= mode;
                     k_q       <= f_start;
                     p_q       <= p_offset;
                     cnt_q     <= dwell;
                     busy_q    <= 1'b1;
                     state_q   <= S_RUN;
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (abort) begin
                  k_q     <= '0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else if (in_range_d) begin
                  k_q   <= nxt_d[KW-1:0];
                  cnt_q <= dwell_q;
               end else if (mode_q) begin
                  k_q   <= f_start_q;
                  cnt_q <= dwell_q;
               end else begin
                  k_q     <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign K       = k_q;
   assign P       = p_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign cfg_err = cfg_err_q;

endmodule
